// File: rtl/jericalla_pkg.sv
// jericalla_pkg
// Shared definitions for the jericalla_evo program sequencer: instruction
// word width, field slice positions, locally handled opcodes and the
// sequencer state enum.
// No ports (package).

package jericalla_pkg;

    localparam int WORD_W = 18;

    // Instruction fields: op | rs1 | rs2 | rd
    localparam int OP_HI  = 17;
    localparam int OP_LO  = 15;
    localparam int RS1_HI = 14;
    localparam int RS1_LO = 10;
    localparam int RS2_HI = 9;
    localparam int RS2_LO = 5;
    localparam int RD_HI  = 4;
    localparam int RD_LO  = 0;

    localparam logic [2:0] OP_BZ   = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    function automatic logic [2:0] get_op(input logic [WORD_W-1:0] w);
        return w[OP_HI:OP_LO];
    endfunction

endpackage

// File: rtl/jericalla_prog_mem.sv
// jericalla_prog_mem
// Program store: DEPTH x 18-bit register array, synchronous write,
// combinational read. Contents are deliberately not reset.
// Ports:
//   clk_jericalla  in   clock
//   we             in   write enable (already qualified by the caller)
//   wr_addr        in   write address
//   wr_data        in   word to write
//   rd_addr        in   read address
//   rd_data        out  word at rd_addr

module jericalla_prog_mem
    import jericalla_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk_jericalla,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_jericalla) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/jericalla_secuenciador.sv
// jericalla_secuenciador
// Issues the words of a loadable program memory to the jericalla_evo core,
// holding each forwarded word for ISSUE_CYCLES cycles. HALT (3'b111) is
// handled locally; with JERICALLA_BZ_EN defined, 3'b110 is a local
// branch-on-zero using zf_jericalla, otherwise it is forwarded.
// Configuration macro: JERICALLA_BZ_EN
// Ports:
//   clk_jericalla, rst_jericalla (async, active-high)
//   wr_en/wr_addr/wr_data  program load (ignored while busy)
//   start, abort           run control (abort wins)
//   zf_jericalla           zero flag from the core
//   instruccion            word driven to the core
//   instr_valid            pulse on the first cycle of a new word
//   busy, done, pc         status
//
// state | meaning
// IDLE  | stopped, waiting for start
// ISSUE | decode mem[pc]: forward, halt or branch
// HOLD  | keep forwarded word stable, then advance pc
// DONE  | halted (explicit or end of memory), waiting for start

module jericalla_secuenciador
    import jericalla_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int ISSUE_CYCLES = 5,
    parameter int AW           = $clog2(DEPTH)
) (
    input  logic              clk_jericalla,
    input  logic              rst_jericalla,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              start,
    input  logic              abort,
    input  logic              zf_jericalla,
    output logic [WORD_W-1:0] instruccion,
    output logic              instr_valid,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     pc
);

    // Hold counter only needs to reach ISSUE_CYCLES-2.
    localparam int CW = (ISSUE_CYCLES > 2) ? $clog2(ISSUE_CYCLES - 1) : 1;

    seq_state_t        state, state_nxt;
    logic [CW-1:0]     hold_cnt;
    logic [WORD_W-1:0] word;
    logic              is_halt, is_bz, bz_taken, at_end, hold_tc;

    jericalla_prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk_jericalla (clk_jericalla),
        .we            (wr_en & ~busy),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .rd_addr       (pc),
        .rd_data       (word)
    );

    assign is_halt = (get_op(word) == OP_HALT);
    assign at_end  = (pc == AW'(DEPTH - 1));
    assign hold_tc = (hold_cnt == '0);

`ifdef JERICALLA_BZ_EN
    assign is_bz    = (get_op(word) == OP_BZ);
    assign bz_taken = zf_jericalla;
`else
    logic unused_zf;
    assign unused_zf = zf_jericalla;
    assign is_bz     = 1'b0;
    assign bz_taken  = 1'b0;
`endif

    always_ff @(posedge clk_jericalla or posedge rst_jericalla) begin
        if (rst_jericalla) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE, DONE: if (start) state_nxt = ISSUE;
                ISSUE: begin
                    if (is_halt) begin
                        state_nxt = DONE;
                    end else if (is_bz) begin
                        // untaken branch off the last word is an implicit halt
                        state_nxt = (!bz_taken && at_end) ? DONE : ISSUE;
                    end else begin
                        state_nxt = HOLD;
                    end
                end
                HOLD: if (hold_tc) state_nxt = at_end ? DONE : ISSUE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state == ISSUE) || (state == HOLD);
        done = (state == DONE);
    end

    always_ff @(posedge clk_jericalla or posedge rst_jericalla) begin
        if (rst_jericalla) begin
            instruccion <= '0;
            instr_valid <= 1'b0;
            pc          <= '0;
            hold_cnt    <= '0;
        end else begin
            instr_valid <= 1'b0;
            if (abort) begin
                instruccion <= '0;
            end else begin
                unique case (state)
                    IDLE, DONE: if (start) pc <= '0;
                    ISSUE: begin
                        if (is_bz) begin
                            if (bz_taken) begin
                                pc <= word[AW-1:0];
                            end else if (!at_end) begin
                                pc <= pc + AW'(1);
                            end
                        end else if (!is_halt) begin
                            instruccion <= word;
                            instr_valid <= 1'b1;
                            hold_cnt    <= CW'(ISSUE_CYCLES - 2);
                        end
                    end
                    HOLD: begin
                        if (hold_tc) begin
                            if (!at_end) pc <= pc + AW'(1);
                        end else begin
                            hold_cnt <= hold_cnt - CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
